// File: rtl/alu_link_pkg.sv
// Shared definitions for the host/ALU UART link: FSM encodings and the
// on-wire command byte order.
package alu_link_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_SEND    = 5'b00010,
    ST_WAIT_TX = 5'b00100,
    ST_WAIT_RX = 5'b01000,
    ST_DONE    = 5'b10000
  } link_state_e;

  localparam logic [1:0] IDX_A  = 2'd0;
  localparam logic [1:0] IDX_B  = 2'd1;
  localparam logic [1:0] IDX_OP = 2'd2;

  localparam int LINK_CMD_BYTES = 3;

endpackage

// File: rtl/alu_host_link_if.sv
// Command, UART byte and result signals of the host-side link initiator.
interface alu_host_link_if #(parameter int SIZE = 8);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SIZE-1:0] cmd_a;
  logic [SIZE-1:0] cmd_b;
  logic [SIZE-1:0] cmd_op;
  logic            tx_start;
  logic [SIZE-1:0] tx_data;
  logic            tx_done;
  logic [SIZE-1:0] rx_data;
  logic            rx_done;
  logic            res_valid;
  logic [SIZE-1:0] res_data;
  logic            res_error;
  logic            busy;

  // master: the link initiator itself
  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, tx_done, rx_data, rx_done,
    output cmd_ready, tx_start, tx_data, res_valid, res_data, res_error, busy
  );

  // slave: host controller plus UART byte cores
  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, tx_done, rx_data, rx_done,
    input  cmd_ready, tx_start, tx_data, res_valid, res_data, res_error, busy
  );
endinterface

// File: rtl/link_timer.sv
// Response timeout counter: cleared on entry to the wait, counts while enabled,
// flags the last allowed cycle.
module link_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= cnt + CW'(1);
  end

  // Never wraps: expiry forces the FSM out of the wait state.
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/alu_host_link.sv
// Host-side link initiator: sends A, B, opcode as three UART bytes, then
// returns the single result byte or a timeout status.
module alu_host_link
  import alu_link_pkg::*;
#(
  parameter int SIZE           = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  alu_host_link_if.master lnk
);

  link_state_e     state;
  logic [1:0]      idx;
  logic [SIZE-1:0] a_q, b_q, op_q;
  logic            tmr_clear, tmr_en, tmr_expired;

  function automatic logic [SIZE-1:0] pick(input logic [1:0] i,
                                           input logic [SIZE-1:0] a,
                                           input logic [SIZE-1:0] b,
                                           input logic [SIZE-1:0] op);
    case (i)
      IDX_A:   pick = a;
      IDX_B:   pick = b;
      IDX_OP:  pick = op;
      default: pick = op;
    endcase
  endfunction

  assign tmr_clear = (state == ST_WAIT_TX) && lnk.tx_done &&
                     (idx == 2'(LINK_CMD_BYTES - 1));
  assign tmr_en    = (state == ST_WAIT_RX);

  link_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      idx           <= IDX_A;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      lnk.cmd_ready <= 1'b0;
      lnk.tx_start  <= 1'b0;
      lnk.tx_data   <= '0;
      lnk.res_valid <= 1'b0;
      lnk.res_data  <= '0;
      lnk.res_error <= 1'b0;
      lnk.busy      <= 1'b0;
    end else begin
      lnk.tx_start  <= 1'b0;
      lnk.res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          lnk.cmd_ready <= 1'b1;
          lnk.busy      <= 1'b0;
          // cmd_ready is registered, so the first cycle out of reset never accepts
          if (lnk.cmd_valid && lnk.cmd_ready) begin
            a_q           <= lnk.cmd_a;
            b_q           <= lnk.cmd_b;
            op_q          <= lnk.cmd_op;
            idx           <= IDX_A;
            lnk.tx_data   <= lnk.cmd_a;
            lnk.tx_start  <= 1'b1;
            lnk.cmd_ready <= 1'b0;
            lnk.busy      <= 1'b1;
            state         <= ST_SEND;
          end
        end
        ST_SEND: state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (lnk.tx_done) begin
            if (idx == 2'(LINK_CMD_BYTES - 1)) begin
              state <= ST_WAIT_RX;
            end else begin
              idx          <= idx + 2'd1;
              lnk.tx_data  <= pick(idx + 2'd1, a_q, b_q, op_q);
              lnk.tx_start <= 1'b1;
              state        <= ST_SEND;
            end
          end
        end
        ST_WAIT_RX: begin
          // a byte arriving on the expiry cycle still counts as a response
          if (lnk.rx_done) begin
            lnk.res_data  <= lnk.rx_data;
            lnk.res_error <= 1'b0;
            lnk.res_valid <= 1'b1;
            state         <= ST_DONE;
          end else if (tmr_expired) begin
            lnk.res_data  <= '0;
            lnk.res_error <= 1'b1;
            lnk.res_valid <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          lnk.cmd_ready <= 1'b1;
          lnk.busy      <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_host_link.sv
// Directed bench: one DUT with the default timeout, one with a 16-cycle
// timeout, both fed the same stimulus; sel picks which one is observed.
module tb_alu_host_link;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       cmd_valid, tx_done, rx_done;
  logic [7:0] cmd_a, cmd_b, cmd_op, rx_data;
  logic       sel;
  int         ntot = 0, npass = 0, nfail = 0;

  alu_host_link_if #(.SIZE(8)) lk ();
  alu_host_link_if #(.SIZE(8)) lk16 ();

  assign lk.cmd_valid   = cmd_valid;  assign lk16.cmd_valid = cmd_valid;
  assign lk.cmd_a       = cmd_a;      assign lk16.cmd_a     = cmd_a;
  assign lk.cmd_b       = cmd_b;      assign lk16.cmd_b     = cmd_b;
  assign lk.cmd_op      = cmd_op;     assign lk16.cmd_op    = cmd_op;
  assign lk.tx_done     = tx_done;    assign lk16.tx_done   = tx_done;
  assign lk.rx_done     = rx_done;    assign lk16.rx_done   = rx_done;
  assign lk.rx_data     = rx_data;    assign lk16.rx_data   = rx_data;

  alu_host_link #(.SIZE(8)) dut (.clk(clk), .reset(reset), .lnk(lk.master));
  alu_host_link #(.SIZE(8), .TIMEOUT_CYCLES(16)) dut16 (.clk(clk), .reset(reset), .lnk(lk16.master));

  logic       o_ready, o_start, o_rvalid, o_rerr, o_busy;
  logic [7:0] o_txd, o_rdata;
  assign o_ready  = sel ? lk16.cmd_ready : lk.cmd_ready;
  assign o_start  = sel ? lk16.tx_start  : lk.tx_start;
  assign o_txd    = sel ? lk16.tx_data   : lk.tx_data;
  assign o_rvalid = sel ? lk16.res_valid : lk.res_valid;
  assign o_rdata  = sel ? lk16.res_data  : lk.res_data;
  assign o_rerr   = sel ? lk16.res_error : lk.res_error;
  assign o_busy   = sel ? lk16.busy      : lk.busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one accepting edge; returns in the tx_start cycle.
  task automatic issue(input logic [7:0] a, b, op, input bit keep);
    int n = 0;
    while (!o_ready && n < 8) begin tick(); n++; end
    chk("issue_ready", o_ready, 1'b1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    tick();
    if (!keep) cmd_valid = 1'b0;
    chk("accept_busy", {o_busy, o_ready}, 2'b10);
  endtask

  // Answer each tx_start with tx_done 10 cycles later; returns in the first WAIT_RX cycle.
  task automatic serve(input logic [7:0] e0, e1, e2, input bit stray);
    logic [7:0] exp [3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx_start%0d", i), o_start, 1'b1);
      chk($sformatf("tx_data%0d", i), o_txd, exp[i]);
      for (int k = 1; k <= 10; k++) begin
        if (stray) begin
          cmd_valid = k[0]; cmd_a = 8'hEE; cmd_b = 8'hDD; cmd_op = 8'hCC;
          rx_done = (k == 5); rx_data = 8'h99;
        end
        tick();
      end
      if (stray) begin cmd_valid = 1'b0; rx_done = 1'b0; end
      chk($sformatf("tx_hold%0d", i), {o_start, o_txd}, {1'b0, exp[i]});
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    chk("wait_rx_busy", {o_busy, o_start}, 2'b10);
  endtask

  task automatic rx_reply(input int n, input logic [7:0] d);
    repeat (n - 1) tick();
    rx_done = 1'b1; rx_data = d;
    tick();
    rx_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    tx_done = 1'b0; rx_done = 1'b0; rx_data = '0;
    repeat (2) tick();
    chk("rst_ctl", {o_ready, o_start, o_rvalid, o_rerr, o_busy}, 5'b0);
    chk("rst_data", {o_txd, o_rdata}, 16'h0);
    reset = 1'b1;
    chk("rdy_pre", o_ready, 1'b0);
    tick();
    chk("rdy_post", o_ready, 1'b1);

    // normal command
    issue(8'h05, 8'h03, 8'h20, 1'b0);
    serve(8'h05, 8'h03, 8'h20, 1'b0);
    rx_reply(20, 8'h08);
    chk("norm_res", {o_rvalid, o_rerr, o_rdata, o_ready}, {1'b1, 1'b0, 8'h08, 1'b0});
    tick();
    chk("norm_after", {o_rvalid, o_ready, o_busy, o_rdata}, {1'b0, 1'b1, 1'b0, 8'h08});

    // stray rx in IDLE, then stray rx and cmd_valid toggling while busy
    rx_done = 1'b1; rx_data = 8'h55;
    tick();
    rx_done = 1'b0;
    tick();
    chk("idle_stray", {o_rvalid, o_rdata, o_start, o_ready}, {1'b0, 8'h08, 1'b0, 1'b1});
    issue(8'h11, 8'h22, 8'h33, 1'b0);
    serve(8'h11, 8'h22, 8'h33, 1'b1);
    rx_reply(5, 8'h44);
    chk("stray_res", {o_rvalid, o_rerr, o_rdata}, {1'b1, 1'b0, 8'h44});
    repeat (4) tick();
    chk("single_txn", {o_start, o_busy, o_ready, o_rvalid}, 4'b0010);

    // back-to-back with cmd_valid held high
    issue(8'h0A, 8'h0B, 8'h0C, 1'b1);
    cmd_a = 8'h1A; cmd_b = 8'h1B; cmd_op = 8'h1C;
    serve(8'h0A, 8'h0B, 8'h0C, 1'b0);
    rx_reply(3, 8'h77);
    chk("b2b_res1", {o_rvalid, o_rdata}, {1'b1, 8'h77});
    tick();
    chk("b2b_gap", {o_ready, o_start}, 2'b10);
    tick();
    chk("b2b_accept", {o_start, o_txd, o_ready}, {1'b1, 8'h1A, 1'b0});
    cmd_valid = 1'b0;
    serve(8'h1A, 8'h1B, 8'h1C, 1'b0);
    rx_reply(2, 8'h99);
    chk("b2b_res2", {o_rvalid, o_rerr, o_rdata}, {1'b1, 1'b0, 8'h99});
    tick();

    // reset after the second tx_start
    issue(8'hC1, 8'hC2, 8'hC3, 1'b0);
    repeat (10) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("mid_tx2", {o_start, o_txd}, {1'b1, 8'hC2});
    #2 reset = 1'b0;
    #1;
    chk("mid_async", {o_start, o_busy, o_ready, o_txd}, {3'b000, 8'h00});
    tick();
    chk("mid_no_res", o_rvalid, 1'b0);
    reset = 1'b1;
    chk("mid_rdy_pre", o_ready, 1'b0);
    tick();
    chk("mid_rdy_post", o_ready, 1'b1);
    issue(8'hD1, 8'hD2, 8'hD3, 1'b0);
    serve(8'hD1, 8'hD2, 8'hD3, 1'b0);
    rx_reply(4, 8'h5A);
    chk("mid_new_res", {o_rvalid, o_rerr, o_rdata}, {1'b1, 1'b0, 8'h5A});
    tick();

    // timeout on the 16-cycle instance
    reset = 1'b0;
    tick();
    reset = 1'b1; sel = 1'b1;
    tick();
    issue(8'h01, 8'h02, 8'h03, 1'b0);
    serve(8'h01, 8'h02, 8'h03, 1'b0);
    repeat (15) tick();
    chk("to_early", o_rvalid, 1'b0);
    tick();
    chk("to_res", {o_rvalid, o_rerr, o_rdata}, {1'b1, 1'b1, 8'h00});
    tick();
    chk("to_after", {o_rvalid, o_ready, o_rerr}, 3'b011);

    // rx_done on the expiry cycle wins
    issue(8'h04, 8'h05, 8'h06, 1'b0);
    serve(8'h04, 8'h05, 8'h06, 1'b0);
    rx_reply(16, 8'hAA);
    chk("race_res", {o_rvalid, o_rerr, o_rdata}, {1'b1, 1'b0, 8'hAA});
    tick();
    chk("race_after", {o_rvalid, o_ready}, 2'b01);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
